crash_monitor: RTL and testbench

Parametrised crash and lives controller for the racing game. It watches the player car sprite and NUM_NPC opponent sprites during scan-out and flags a crash when an opaque car pixel and an opaque NPC pixel fall on the same DrawX/DrawY. It then runs the crash, invulnerability and game-over sequence, counted in frames. It sits between the sprite ROM address generators and the car/NPC motion and scoring logic, whose freeze and restart it drives.

---
 rtl/crash_pkg.sv | 24 ++
 rtl/frame_counter.sv | 41 ++++
 rtl/crash_monitor.sv | 190 +++++++++++++++++++
 tb/tb_crash_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/crash_pkg.sv
// Shared types and helpers for the crash and lives controller.
// Holds the controller state encoding and the sprite opacity test.
package crash_pkg;

    typedef enum logic [1:0] {
        PLAY,
        CRASH,
        INVULN,
        OVER
    } crash_state_t;

    // Blink toggles once per this many frames while invulnerable.
    localparam int BLINK_PERIOD = 8;

    // A sprite pixel collides only when drawn and outside the clear range.
    function automatic logic is_opaque(
        input logic        draw,
        input logic [31:0] addr,
        input logic [31:0] clear_max
    );
        return draw && (addr > clear_max);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame counter shared by the timed crash states.
// Raises done on the frame pulse that completes the terminal count.
module frame_counter #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic          frame_start_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] count_o,
    output logic          done_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise step once per counted frame.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && frame_start_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign done_o  = en_i && frame_start_i && (count_q == term_i);

endmodule

// File: rtl/crash_monitor.sv
// Crash detection and lives controller for the racing game.
// Flags car/NPC sprite overlap and sequences crash, immunity, game over.
module crash_monitor
    import crash_pkg::*;
#(
    parameter int                NUM_NPC       = 4,
    parameter int                ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] CLEAR_MAX     = 8'h05,
    parameter int                LIVES         = 3,
    parameter int                CRASH_FRAMES  = 60,
    parameter int                INVULN_FRAMES = 120,
    parameter logic [7:0]        RESTART_KEY   = 8'h15,
    localparam int               HW   = (NUM_NPC > 1) ? $clog2(NUM_NPC) : 1,
    localparam int               LW   = $clog2(LIVES + 1),
    localparam int               FMAX = (CRASH_FRAMES > INVULN_FRAMES) ?
                                        CRASH_FRAMES : INVULN_FRAMES,
    localparam int               CW   = (FMAX > 1) ? $clog2(FMAX) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      draw_car,
    input  logic [ADDR_W-1:0]         car_addr,
    input  logic [NUM_NPC-1:0]        draw_npc,
    input  logic [NUM_NPC*ADDR_W-1:0] npc_addr,
    input  logic                      frame_start,
    input  logic [7:0]                keycode,
    output logic                      crash_pulse,
    output logic [HW-1:0]             hit_idx,
    output logic [LW-1:0]             lives_left,
    output logic                      freeze,
    output logic                      blink,
    output logic                      game_over
);

    crash_state_t  state_q, state_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [HW-1:0] hit_idx_q, hit_idx_d;
    logic          pulse_q, pulse_d;
    logic          freeze_q, freeze_d;
    logic          blink_q, blink_d;
    logic          over_q, over_d;

    logic          hit;
    logic [HW-1:0] hit_sel;
    logic          cnt_en;
    logic          cnt_clear;
    logic [CW-1:0] cnt_term;
    logic [CW-1:0] cnt;
    logic          cnt_done;
    logic          restart;

    // Overlap test and lowest-index priority encode of opaque NPCs.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        if (is_opaque(draw_car, 32'(car_addr), 32'(CLEAR_MAX))) begin
            for (int i = NUM_NPC - 1; i >= 0; i--) begin
                if (is_opaque(draw_npc[i],
                              32'(npc_addr[i*ADDR_W +: ADDR_W]),
                              32'(CLEAR_MAX))) begin
                    hit     = 1'b1;
                    hit_sel = HW'(i);
                end
            end
        end
    end

    assign restart   = (keycode == RESTART_KEY);
    assign cnt_en    = (state_q == CRASH) || (state_q == INVULN);
    assign cnt_clear = (state_d != state_q);
    assign cnt_term  = (state_q == CRASH) ? CW'(CRASH_FRAMES - 1)
                                          : CW'(INVULN_FRAMES - 1);

    frame_counter #(
        .CW (CW)
    ) u_frame_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_i       (cnt_clear),
        .en_i          (cnt_en),
        .frame_start_i (frame_start),
        .term_i        (cnt_term),
        .count_o       (cnt),
        .done_o        (cnt_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; hits only matter while playing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLAY: begin
                if (hit) begin
                    state_d = CRASH;
                end
            end
            CRASH: begin
                if (cnt_done) begin
                    state_d = (lives_q == '0) ? OVER : INVULN;
                end
            end
            INVULN: begin
                if (cnt_done) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (restart) begin
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // Output next values, computed from the transition being taken.
    always_comb begin
        lives_d   = lives_q;
        hit_idx_d = hit_idx_q;
        blink_d   = blink_q;
        pulse_d   = 1'b0;
        unique case (state_q)
            PLAY: begin
                blink_d = 1'b0;
                if (hit) begin
                    lives_d   = (lives_q == '0) ? '0 : lives_q - LW'(1);
                    hit_idx_d = hit_sel;
                    pulse_d   = 1'b1;
                end
            end
            CRASH: begin
                blink_d = cnt_done && (lives_q != '0);
            end
            INVULN: begin
                if (cnt_done) begin
                    blink_d = 1'b0;
                end else if (frame_start &&
                             ((cnt & CW'(BLINK_PERIOD - 1)) ==
                              CW'(BLINK_PERIOD - 1))) begin
                    blink_d = ~blink_q;
                end
            end
            OVER: begin
                blink_d = 1'b0;
                if (restart) begin
                    lives_d   = LW'(LIVES);
                    hit_idx_d = '0;
                end
            end
            default: blink_d = 1'b0;
        endcase
        freeze_d = (state_d == CRASH) || (state_d == OVER);
        over_d   = (state_d == OVER);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lives_q   <= LW'(LIVES);
            hit_idx_q <= '0;
            pulse_q   <= 1'b0;
            freeze_q  <= 1'b0;
            blink_q   <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            lives_q   <= lives_d;
            hit_idx_q <= hit_idx_d;
            pulse_q   <= pulse_d;
            freeze_q  <= freeze_d;
            blink_q   <= blink_d;
            over_q    <= over_d;
        end
    end

    assign crash_pulse = pulse_q;
    assign hit_idx     = hit_idx_q;
    assign lives_left  = lives_q;
    assign freeze      = freeze_q;
    assign blink       = blink_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_crash_monitor.sv
// Directed bench for crash_monitor with default parameters.
// Inputs change after the falling edge; outputs are checked there too.
module tb_crash_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        draw_car;
    logic [7:0]  car_addr;
    logic [3:0]  draw_npc;
    logic [31:0] npc_addr;
    logic        frame_start;
    logic [7:0]  keycode;
    logic        crash_pulse;
    logic [1:0]  hit_idx;
    logic [1:0]  lives_left;
    logic        freeze;
    logic        blink;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crash_monitor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .draw_car    (draw_car),
        .car_addr    (car_addr),
        .draw_npc    (draw_npc),
        .npc_addr    (npc_addr),
        .frame_start (frame_start),
        .keycode     (keycode),
        .crash_pulse (crash_pulse),
        .hit_idx     (hit_idx),
        .lives_left  (lives_left),
        .freeze      (freeze),
        .blink       (blink),
        .game_over   (game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
    endtask

    task automatic set_hit(input logic [3:0] mask, input logic [7:0] a);
        draw_car = 1'b1;
        car_addr = 8'h20;
        draw_npc = mask;
        npc_addr = {a, a, a, a};
    endtask

    task automatic no_hit();
        draw_car = 1'b0;
        draw_npc = 4'b0000;
    endtask

    task automatic crash_once();
        set_hit(4'b0001, 8'h30);
        step();
        no_hit();
    endtask

    initial begin
        reset_n     = 1'b0;
        draw_car    = 1'b0;
        car_addr    = 8'h00;
        draw_npc    = 4'b0000;
        npc_addr    = 32'h0;
        frame_start = 1'b0;
        keycode     = 8'h00;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst_lives", 32'(lives_left), 3);
        check("rst_idx", 32'(hit_idx), 0);
        check("rst_pulse", 32'(crash_pulse), 0);
        check("rst_freeze", 32'(freeze), 0);
        check("rst_blink", 32'(blink), 0);
        check("rst_over", 32'(game_over), 0);

        // Background NPC pixel does not collide.
        draw_car = 1'b1;
        car_addr = 8'h20;
        draw_npc = 4'b0100;
        npc_addr = 32'h0;
        npc_addr[16 +: 8] = 8'h05;
        step();
        no_hit();
        step();
        check("bg_pulse", 32'(crash_pulse), 0);
        check("bg_freeze", 32'(freeze), 0);
        check("bg_lives", 32'(lives_left), 3);

        // Opaque overlap on NPC 2, held for two pixels.
        npc_addr = 32'h0;
        npc_addr[16 +: 8] = 8'h30;
        draw_car = 1'b1;
        draw_npc = 4'b0100;
        step();
        check("hit_pulse", 32'(crash_pulse), 1);
        check("hit_idx", 32'(hit_idx), 2);
        check("hit_lives", 32'(lives_left), 2);
        check("hit_freeze", 32'(freeze), 1);
        step();
        no_hit();
        check("hold_pulse", 32'(crash_pulse), 0);
        check("hold_lives", 32'(lives_left), 2);

        // Restart key is ignored outside game over.
        keycode = 8'h15;
        frames(59);
        keycode = 8'h00;
        check("c59_freeze", 32'(freeze), 1);
        check("c59_over", 32'(game_over), 0);
        frames(1);
        check("c60_freeze", 32'(freeze), 0);
        check("c60_blink", 32'(blink), 1);

        // Overlap while invulnerable is ignored.
        set_hit(4'b0010, 8'h30);
        step();
        check("inv_pulse", 32'(crash_pulse), 0);
        step();
        no_hit();
        check("inv_lives", 32'(lives_left), 2);

        frames(7);
        check("inv7_blink", 32'(blink), 1);
        frames(1);
        check("inv8_blink", 32'(blink), 0);
        frames(111);
        check("inv119_blink", 32'(blink), 1);
        frames(1);
        check("inv120_blink", 32'(blink), 0);
        check("inv120_freeze", 32'(freeze), 0);

        // Simultaneous hits on NPC 1 and 3; lowest index wins.
        set_hit(4'b1010, 8'h30);
        step();
        check("pri_pulse", 32'(crash_pulse), 1);
        check("pri_idx", 32'(hit_idx), 1);
        check("pri_lives", 32'(lives_left), 1);
        step();
        no_hit();
        check("pri_single", 32'(crash_pulse), 0);

        // Asynchronous reset in the middle of the crash count.
        frames(30);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_lives", 32'(lives_left), 3);
        check("arst_freeze", 32'(freeze), 0);
        check("arst_idx", 32'(hit_idx), 0);
        step();
        reset_n = 1'b1;
        step();

        // Frame pulse coincident with the hit is not counted.
        set_hit(4'b0001, 8'h30);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        no_hit();
        check("c2_lives", 32'(lives_left), 2);
        frames(59);
        check("c2_59_freeze", 32'(freeze), 1);
        frames(1);
        check("c2_60_freeze", 32'(freeze), 0);
        frames(120);

        crash_once();
        check("c3_lives", 32'(lives_left), 1);
        frames(180);
        check("c3_done_freeze", 32'(freeze), 0);

        crash_once();
        check("c4_lives", 32'(lives_left), 0);
        frames(59);
        check("c4_59_over", 32'(game_over), 0);
        frames(1);
        check("over_flag", 32'(game_over), 1);
        check("over_freeze", 32'(freeze), 1);
        check("over_lives", 32'(lives_left), 0);
        check("over_blink", 32'(blink), 0);

        keycode = 8'h14;
        step();
        step();
        check("wrongkey_over", 32'(game_over), 1);

        // Restart key together with a hit while in game over.
        keycode = 8'h15;
        set_hit(4'b0100, 8'h30);
        step();
        keycode = 8'h00;
        no_hit();
        check("rs_over", 32'(game_over), 0);
        check("rs_lives", 32'(lives_left), 3);
        check("rs_idx", 32'(hit_idx), 0);
        check("rs_pulse", 32'(crash_pulse), 0);
        check("rs_freeze", 32'(freeze), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
